stage_ctrl: RTL and testbench
=============================

// Module: stage_ctrl
// PURPOSE
//  Multi-cycle sequencer for the single-issue core. Steps each instruction through
//  FETCH/DECODE/OPLOAD/EXEC/MEM/WB and drives the ALU's stage_i bus.
//  Drives the ALU's readin_a/b/pass operand-latch strobes and the imem/dmem request handshakes.
//  Traps on memory timeout or an illegal instruction type.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles for imem/dmem ack before TRAP; 0 = never time out
//  RETIRE_W     32  width of the retired-instruction counter
// PORTS
//  clk            in   1         clock, all state updates on rising edge
//  reset          in   1         synchronous, active-high
//  halt_i         in   1         hold core in FETCH, no new fetch issued
//  itype_i        in   5         instruction class from decode (itype.v encodings)
//  imem_req_o     out  1         instruction fetch request
//  imem_ack_i     in   1         fetch data valid; IR loads on this cycle
//  ir_load_o      out  1         1-cycle pulse: latch fetched word into IR
//  stage_o        out  3         current stage, wired to ALU stage_i
//  readin_a_o     out  1         1-cycle operand-A latch strobe
//  readin_b_o     out  1         1-cycle operand-B latch strobe
//  readin_pass_o  out  1         1-cycle store-data latch strobe (STYPE only)
//  dmem_req_o     out  1         data memory request
//  dmem_we_o      out  1         data write enable, valid with dmem_req_o
//  dmem_ack_i     in   1         data access complete
//  rf_we_o        out  1         register-file write strobe
//  pc_inc_o       out  1         1-cycle PC advance pulse
//  err_o          out  1         sticky: core trapped
//  cycle_cnt_o    out  32        free-running cycle count (see CONFIGURATION)
//  retire_cnt_o   out  RETIRE_W  instructions retired (see CONFIGURATION)
// BEHAVIOUR
//  - Stage encoding: FETCH=0, DECODE=1, OPLOAD=2, EXEC=3, MEM=4, WB=5, TRAP=7. Code 6 is unused.
//    Any illegal state value goes to TRAP.
//  - Reset: stage=FETCH; all outputs 0; err_o=0; counters=0; timeout counter=0.
//    Reset mid-instruction aborts it. Outputs drop in the cycle after the reset edge.
//  - Output decode:
//    - readin_*, ir_load_o, rf_we_o and pc_inc_o are Moore outputs of the registered stage.
//      They are glitch-free and high for exactly one cycle, because the ALU latches on their rising edges.
//    - imem_req_o = (stage==FETCH) & ~halt_i & ~reset.
//  - FETCH
//    - Hold imem_req_o until imem_ack_i.
//    - Ack in the same cycle as the request is legal and goes to DECODE on the next edge.
//    - halt_i=1 keeps the core in FETCH with the request low. A halt during a later stage takes effect at the next FETCH.
//  - DECODE: ir_load_o=1 for this one cycle. Latch itype_i into itype_q. Go to OPLOAD.
//  - OPLOAD
//    - readin_a_o=readin_b_o=1 for this cycle; readin_pass_o=1 only if itype_q==STYPE.
//    - If itype_q is not one of RTYPE/ITYPE/STYPE/UTYPE/LTYPE, go to TRAP and assert no strobes.
//    - Otherwise go to EXEC.
//  - EXEC: exactly one cycle, during which the ALU computes. LTYPE/STYPE go to MEM; all others go to WB.
//  - MEM: dmem_req_o=1, dmem_we_o=(itype_q==STYPE), both held until dmem_ack_i, then go to WB.
//  - WB: pc_inc_o=1; rf_we_o=1 unless STYPE; retire_cnt++ (wraps); go to FETCH.
//  - Timeout
//    - The wait counter counts FETCH cycles with the request high, and MEM cycles. It clears on stage change.
//    - If MEM_TIMEOUT cycles elapse with no ack: go to TRAP and set err_o.
//    - An ack on the last allowed cycle wins over the timeout.
//  - TRAP: all strobes and requests 0; err_o=1; leaves only on reset.
//  - Latency, zero-wait memory: R/I/U-type 5 cycles, L/S-type 6 cycles (FETCH entry to next FETCH).
// CONFIGURATION
//  - STAGE_CTRL_PERF_EN defined:
//    - cycle_cnt_o increments every non-reset cycle (wraps at 2^32).
//    - retire_cnt_o increments at WB (wraps at 2^RETIRE_W).
//  - Not defined: no counter registers; cycle_cnt_o and retire_cnt_o tied to 0.
// TESTING
//  - RTYPE ADD, imem_ack same-cycle:
//    - stage_o sequence is 0,1,2,3,5,0.
//    - readin_a/b high only at stage 2; readin_pass stays 0.
//    - rf_we_o and pc_inc_o pulse once at stage 5.
//  - STYPE, dmem_ack after 3 waits:
//    - stage_o sequence is 0,1,2,3,4,4,4,4,5.
//    - readin_pass pulses at stage 2; dmem_we_o=1 throughout MEM; rf_we_o=0 at WB.
//  - LTYPE with no dmem_ack, MEM_TIMEOUT=16: TRAP (stage_o=7) after 16 MEM cycles, err_o=1, all requests 0.
//  - itype_i=5'h1F at DECODE: TRAP from OPLOAD, no readin strobes, err_o=1. Reset returns to FETCH with err_o=0.
//  - halt_i high during FETCH for 10 cycles: imem_req_o=0 and stage_o=0 throughout; fetch resumes the cycle halt drops.
//  - Reset asserted in MEM (dmem_req_o=1), with STAGE_CTRL_PERF_EN defined:
//    - dmem_req_o=0 and stage_o=0 the next cycle.
//    - After 3 ADDs, retire_cnt_o=3.

Source files
------------

// File: rtl/stage_ctrl.sv
// stage_ctrl: multi-cycle sequencer for the single-issue core.
// Steps each instruction through FETCH/DECODE/OPLOAD/EXEC/MEM/WB, drives the ALU stage bus,
// operand-latch strobes and the imem/dmem request handshakes, and traps on memory timeout or an
// illegal instruction class.
//
// Optional feature macro: STAGE_CTRL_PERF_EN (cycle / retired-instruction counters).
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   halt_i            hold in FETCH without issuing a fetch
//   itype_i           instruction class from decode, latched in DECODE
//   imem_req_o/ack_i  instruction fetch handshake
//   ir_load_o         IR latch pulse (DECODE)
//   stage_o           current stage (ALU stage_i)
//   readin_a/b/pass_o operand / store-data latch strobes (OPLOAD)
//   dmem_req_o/we_o   data request and write enable (MEM); dmem_ack_i completes it
//   rf_we_o, pc_inc_o writeback strobes (WB)
//   err_o             sticky trap flag
//   cycle_cnt_o       free-running cycle count (0 unless STAGE_CTRL_PERF_EN)
//   retire_cnt_o      retired instruction count (0 unless STAGE_CTRL_PERF_EN)
module stage_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt_i,
  input  logic [4:0]          itype_i,
  output logic                imem_req_o,
  input  logic                imem_ack_i,
  output logic                ir_load_o,
  output logic [2:0]          stage_o,
  output logic                readin_a_o,
  output logic                readin_b_o,
  output logic                readin_pass_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  input  logic                dmem_ack_i,
  output logic                rf_we_o,
  output logic                pc_inc_o,
  output logic                err_o,
  output logic [31:0]         cycle_cnt_o,
  output logic [RETIRE_W-1:0] retire_cnt_o
);

  // Instruction class encodings (itype.v).
  localparam logic [4:0] ItypeR = 5'd0;
  localparam logic [4:0] ItypeI = 5'd1;
  localparam logic [4:0] ItypeS = 5'd2;
  localparam logic [4:0] ItypeL = 5'd3;
  localparam logic [4:0] ItypeU = 5'd4;

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StOpload = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd7
  } stage_e;

  stage_e           stage_q, stage_d;
  logic [4:0]       itype_q;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q;
  logic             legal, is_store, is_mem, counting, timeout_hit;

  assign legal    = (itype_q == ItypeR) || (itype_q == ItypeI) || (itype_q == ItypeS) ||
                    (itype_q == ItypeU) || (itype_q == ItypeL);
  assign is_store = (itype_q == ItypeS);
  assign is_mem   = (itype_q == ItypeS) || (itype_q == ItypeL);

  // Moore decode of the registered stage; imem_req_o is the only input-dependent output.
  assign imem_req_o    = (stage_q == StFetch) & ~halt_i & ~reset;
  assign ir_load_o     = (stage_q == StDecode);
  assign readin_a_o    = (stage_q == StOpload) & legal;
  assign readin_b_o    = (stage_q == StOpload) & legal;
  assign readin_pass_o = (stage_q == StOpload) & is_store;
  assign dmem_req_o    = (stage_q == StMem);
  assign dmem_we_o     = (stage_q == StMem) & is_store;
  assign rf_we_o       = (stage_q == StWb) & ~is_store;
  assign pc_inc_o      = (stage_q == StWb);
  assign stage_o       = stage_q;
  assign err_o         = err_q;

  // Halted FETCH cycles do not count toward the fetch timeout.
  assign counting    = ((stage_q == StFetch) & imem_req_o) | (stage_q == StMem);
  assign timeout_hit = (MEM_TIMEOUT != 0) && counting && (wait_q == WaitMax);

  always_comb begin
    stage_d = stage_q;
    wait_d  = wait_q;
    case (stage_q)
      StFetch: begin
        if (imem_req_o) begin
          // Ack on the last allowed cycle takes priority over the timeout.
          if (imem_ack_i)       stage_d = StDecode;
          else if (timeout_hit) stage_d = StTrap;
        end
      end
      StDecode: stage_d = StOpload;
      StOpload: stage_d = legal ? StExec : StTrap;
      StExec:   stage_d = is_mem ? StMem : StWb;
      StMem: begin
        if (dmem_ack_i)       stage_d = StWb;
        else if (timeout_hit) stage_d = StTrap;
      end
      StWb:     stage_d = StFetch;
      StTrap:   stage_d = StTrap;
      default:  stage_d = StTrap;
    endcase

    if (stage_d != stage_q) wait_d = '0;
    else if (counting)      wait_d = wait_q + WaitW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= StFetch;
      itype_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      wait_q  <= wait_d;
      if (stage_q == StDecode) itype_q <= itype_i;
      if (stage_d == StTrap)   err_q   <= 1'b1;
    end
  end

`ifdef STAGE_CTRL_PERF_EN
  logic [31:0]         cycle_cnt_q;
  logic [RETIRE_W-1:0] retire_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (stage_q == StWb) retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
    end
  end

  assign cycle_cnt_o  = cycle_cnt_q;
  assign retire_cnt_o = retire_cnt_q;
`else
  assign cycle_cnt_o  = '0;
  assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stage_ctrl.sv
// tb_stage_ctrl: scoreboard bench for stage_ctrl. Each stimulus cycle pushes the hand-computed
// expected output vector; a negedge monitor pops and compares against the DUT outputs.
module tb_stage_ctrl;

  localparam logic [4:0] R = 5'd0;
  localparam logic [4:0] I = 5'd1;
  localparam logic [4:0] S = 5'd2;
  localparam logic [4:0] L = 5'd3;
  localparam logic [4:0] U = 5'd4;

  // Expected vector: {stage[2:0], imem_req, ir_load, ra, rb, rpass, dreq, dwe, rfwe, pcinc, err}
  localparam logic [12:0] IREQ = 13'h200;
  localparam logic [12:0] IRL  = 13'h100;
  localparam logic [12:0] RA   = 13'h080;
  localparam logic [12:0] RB   = 13'h040;
  localparam logic [12:0] RP   = 13'h020;
  localparam logic [12:0] DREQ = 13'h010;
  localparam logic [12:0] DWE  = 13'h008;
  localparam logic [12:0] RFWE = 13'h004;
  localparam logic [12:0] PCI  = 13'h002;
  localparam logic [12:0] ERR  = 13'h001;
  localparam logic [12:0] S0 = 13'h0000, S1 = 13'h0400, S2 = 13'h0800, S3 = 13'h0c00;
  localparam logic [12:0] S4 = 13'h1000, S5 = 13'h1400, S7 = 13'h1c00;

  logic        clk = 1'b0;
  logic        reset, halt, imem_ack, dmem_ack;
  logic [4:0]  itype;
  logic        imem_req, ir_load, ra, rb, rp, dreq, dwe, rfwe, pci, err;
  logic [2:0]  stage;
  logic [31:0] cycle_cnt, retire_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [12:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  stage_ctrl #(.MEM_TIMEOUT(16), .RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .halt_i(halt), .itype_i(itype),
    .imem_req_o(imem_req), .imem_ack_i(imem_ack), .ir_load_o(ir_load), .stage_o(stage),
    .readin_a_o(ra), .readin_b_o(rb), .readin_pass_o(rp),
    .dmem_req_o(dreq), .dmem_we_o(dwe), .dmem_ack_i(dmem_ack),
    .rf_we_o(rfwe), .pc_inc_o(pci), .err_o(err),
    .cycle_cnt_o(cycle_cnt), .retire_cnt_o(retire_cnt)
  );

  // Monitor: one expected vector per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e, got;
      string       t;
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = {stage, imem_req, ir_load, ra, rb, rp, dreq, dwe, rfwe, pci, err};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL %s: outputs got %h required %h", t, got, e);
      end
    end
  end

  task automatic check32(input string t, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", t, got, req);
    end
  endtask

  task automatic step(input logic h, input logic [4:0] it, input logic ia, input logic da,
                      input logic r, input logic [12:0] e, input string t);
    halt     = h;
    itype    = it;
    imem_ack = ia;
    dmem_ack = da;
    reset    = r;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Non-memory instruction; fw = fetch wait cycles before imem ack.
  task automatic instr_rui(input logic [4:0] it, input int fw, input string t);
    for (int i = 0; i < fw; i++) step(0, it, 0, 0, 0, S0 | IREQ, {t, "_fwait"});
    step(0, it, 1, 0, 0, S0 | IREQ, {t, "_fetch"});
    step(0, it, 0, 0, 0, S1 | IRL, {t, "_decode"});
    step(0, it, 0, 0, 0, S2 | RA | RB, {t, "_opload"});
    step(0, it, 0, 0, 0, S3, {t, "_exec"});
    step(0, it, 0, 0, 0, S5 | RFWE | PCI, {t, "_wb"});
  endtask

  // Load/store; mw = MEM cycles without ack before the acking cycle.
  task automatic instr_mem(input logic [4:0] it, input int mw, input string t);
    logic st;
    st = (it == S);
    step(0, it, 1, 0, 0, S0 | IREQ, {t, "_fetch"});
    step(0, it, 0, 0, 0, S1 | IRL, {t, "_decode"});
    step(0, it, 0, 0, 0, S2 | RA | RB | (st ? RP : 13'h0), {t, "_opload"});
    step(0, it, 0, 0, 0, S3, {t, "_exec"});
    for (int i = 0; i < mw; i++) step(0, it, 0, 0, 0, S4 | DREQ | (st ? DWE : 13'h0), {t, "_memwait"});
    step(0, it, 0, 1, 0, S4 | DREQ | (st ? DWE : 13'h0), {t, "_memack"});
    step(0, it, 0, 0, 0, S5 | PCI | (st ? 13'h0 : RFWE), {t, "_wb"});
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; itype = R; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    step(0, R, 1, 0, 1, S0, "reset_state");
    check32("reset_cycle_cnt", cycle_cnt, 32'd0);
    check32("reset_retire_cnt", retire_cnt, 32'd0);

    instr_rui(R, 0, "add");
    instr_rui(I, 2, "itype");
    instr_rui(U, 0, "utype");
    instr_mem(L, 0, "load0");
    instr_mem(S, 3, "store3");

    for (int i = 0; i < 10; i++) step(1, R, 1, 0, 0, S0, "halt");
    instr_rui(R, 0, "add_after_halt");

    instr_mem(L, 15, "load_ack_last");

    // Load with no dmem ack: 16 MEM cycles then TRAP.
    step(0, L, 1, 0, 0, S0 | IREQ, "tmo_fetch");
    step(0, L, 0, 0, 0, S1 | IRL, "tmo_decode");
    step(0, L, 0, 0, 0, S2 | RA | RB, "tmo_opload");
    step(0, L, 0, 0, 0, S3, "tmo_exec");
    for (int i = 0; i < 16; i++) step(0, L, 0, 0, 0, S4 | DREQ, "tmo_mem");
    step(0, L, 1, 1, 0, S7 | ERR, "tmo_trap");
    step(0, L, 1, 1, 0, S7 | ERR, "tmo_trap_hold");
    step(0, L, 1, 0, 1, S7 | ERR, "tmo_reset");

    // Illegal instruction class.
    step(0, 5'h1F, 1, 0, 0, S0 | IREQ, "ill_fetch");
    step(0, 5'h1F, 0, 0, 0, S1 | IRL, "ill_decode");
    step(0, 5'h1F, 0, 0, 0, S2, "ill_opload");
    step(0, 5'h1F, 0, 0, 0, S7 | ERR, "ill_trap");
    step(0, 5'h1F, 0, 0, 1, S7 | ERR, "ill_reset");

    // Reset while in MEM aborts the load.
    step(0, L, 1, 0, 0, S0 | IREQ, "rm_fetch");
    step(0, L, 0, 0, 0, S1 | IRL, "rm_decode");
    step(0, L, 0, 0, 0, S2 | RA | RB, "rm_opload");
    step(0, L, 0, 0, 0, S3, "rm_exec");
    step(0, L, 0, 0, 0, S4 | DREQ, "rm_mem");
    step(0, L, 0, 0, 1, S4 | DREQ, "rm_reset");
    instr_rui(R, 0, "post_rst_add1");
    instr_rui(R, 0, "post_rst_add2");
    instr_rui(R, 0, "post_rst_add3");

`ifdef STAGE_CTRL_PERF_EN
    check32("retire_cnt_3adds", retire_cnt, 32'd3);
    check32("cycle_cnt_3adds", cycle_cnt, 32'd15);
`else
    check32("retire_cnt_tied", retire_cnt, 32'd0);
    check32("cycle_cnt_tied", cycle_cnt, 32'd0);
`endif

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
